// File: rtl/acf_stream_pkg.sv
// acf_stream_pkg: shared state encoding, header layout and frame geometry for the ACF streamer.
package acf_stream_pkg;
  typedef enum logic [1:0] {IDLE, HDR, CNT, ACF} state_t;
  localparam int FID_W = 16;
  localparam int NCH_W = 8;
  localparam int NB_W = 8;
  localparam int BS_W = 8;
  localparam int BS_OFF = 0;
  localparam int NB_OFF = BS_OFF + BS_W;
  localparam int NCH_OFF = NB_OFF + NB_W;
  localparam int FID_OFF = NCH_OFF + NCH_W;
  localparam int HDR_W = FID_OFF + FID_W;
  function automatic int words_per_ch(input int num_bins, input int bin_size);
    return bin_size * (num_bins + 1);
  endfunction
  function automatic int frame_len(input int num_ch, input int num_bins, input int bin_size);
    return 1 + num_ch * (1 + words_per_ch(num_bins, bin_size));
  endfunction
  function automatic logic [HDR_W-1:0] hdr_word(input logic [FID_W-1:0] fid, input int nch, input int nb, input int bs);
    hdr_word = '0;
    hdr_word[FID_OFF +: FID_W] = fid;
    hdr_word[NCH_OFF +: NCH_W] = NCH_W'(nch);
    hdr_word[NB_OFF +: NB_W] = NB_W'(nb);
    hdr_word[BS_OFF +: BS_W] = BS_W'(bs);
  endfunction
endpackage

// File: rtl/acf_edge_counter.sv
// acf_edge_counter: synchronises one SPCM input, strobes rising edges and keeps a saturating photon count.
module acf_edge_counter
  import acf_stream_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter bit CLR = 1'b0
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             CE,
  input  logic             ch,
  input  logic             take,
  output logic             rise,
  output logic [CNT_W-1:0] snap
);
  logic s1, s2, prev;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
      cnt <= '0;
      snap <= '0;
    end else begin
      s1 <= ch;
      s2 <= s1;
      prev <= s2;
      rise <= CE & s2 & ~prev;
      if (take) snap <= cnt;
      // a strobe landing on the clear cycle is kept, so the fresh count starts at 1
      cnt <= (take && CLR) ? CNT_W'(rise) : (rise && !(&cnt)) ? cnt + 1'b1 : cnt;
    end
endmodule

// File: rtl/multi_channel_acf_streamer.sv
// multi_channel_acf_streamer: counts photons per channel and streams a header/count/ACF frame
// over a ready/valid port on request.
module multi_channel_acf_streamer
  import acf_stream_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int NUM_BINS = 20,
  parameter int BIN_SIZE = 8,
  parameter int ACF_W = NUM_BINS + 33,
  parameter int CNT_W = 32,
  parameter int CLR_ON_TX = 0,
  localparam int WORDS = words_per_ch(NUM_BINS, BIN_SIZE)
) (
  input  logic                          CLK,
  input  logic                          rst_n,
  input  logic                          CE,
  input  logic [NUM_CH-1:0]             ch_in,
  input  logic [NUM_CH*WORDS*ACF_W-1:0] acf_in,
  input  logic [NUM_CH-1:0]             acf_busy,
  input  logic                          init_tx,
  output logic [ACF_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          tx_busy,
  output logic                          tx_overrun,
  output logic [NUM_CH-1:0]             rise_pulse
);
  localparam int CW = $clog2(NUM_CH + 1);
  localparam int KW = $clog2(WORDS + 1);
  localparam logic [CW-1:0] C_LAST = CW'(NUM_CH - 1);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);
  state_t state, state_n;
  logic [CW-1:0] ch, ch_n;
  logic [KW-1:0] k, k_n, kk;
  logic [ACF_W-1:0] data_n, word;
  logic valid_n, last_n, ovr_n, take, fire, busy_c;
  logic [FID_W-1:0] fid, fid_n;
  logic [NUM_CH*CNT_W-1:0] snaps;
  assign take = init_tx && state == IDLE;
  assign fire = out_valid & out_ready;
  assign tx_busy = state != IDLE;
  assign busy_c = acf_busy[int'(ch) +: 1];
  // index of the ACF word to fetch next: first word after a count, else the one pending or following
  assign kk = (state == CNT) ? '0 : (out_valid ? k + 1'b1 : k);
  assign word = acf_in[(int'(ch) * WORDS + int'(kk)) * ACF_W +: ACF_W];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    acf_edge_counter #(.CNT_W(CNT_W), .CLR(CLR_ON_TX != 0)) u_cnt (
      .CLK(CLK),
      .rst_n(rst_n),
      .CE(CE),
      .ch(ch_in[i]),
      .take(take),
      .rise(rise_pulse[i]),
      .snap(snaps[i*CNT_W +: CNT_W])
    );
  end
  always_comb begin
    state_n = state;
    ch_n = ch;
    k_n = k;
    data_n = out_data;
    valid_n = out_valid;
    last_n = out_last;
    fid_n = fid;
    ovr_n = take ? 1'b0 : (init_tx ? 1'b1 : tx_overrun);
    case (state)
      IDLE: if (init_tx) begin
        state_n = HDR;
        ch_n = '0;
        k_n = '0;
        data_n = ACF_W'(hdr_word(fid, NUM_CH, NUM_BINS, BIN_SIZE));
        valid_n = 1'b1;
        last_n = 1'b0;
      end
      HDR: if (fire) begin
        state_n = CNT;
        data_n = ACF_W'(snaps[CNT_W-1:0]);
      end
      CNT: if (fire) begin
        state_n = ACF;
        k_n = '0;
        data_n = word;
        valid_n = !busy_c;
        last_n = !busy_c && ch == C_LAST && K_LAST == '0;
      end
      ACF: if (fire && k == K_LAST) begin
        if (ch == C_LAST) begin
          state_n = IDLE;
          valid_n = 1'b0;
          last_n = 1'b0;
          fid_n = fid + 1'b1;
        end else begin
          state_n = CNT;
          ch_n = ch + 1'b1;
          data_n = ACF_W'(snaps[(int'(ch) + 1) * CNT_W +: CNT_W]);
          valid_n = 1'b1;
          last_n = 1'b0;
        end
      end else if (fire || !out_valid) begin
        // a word is only latched while its channel's ACF is stable; once latched it holds
        k_n = kk;
        data_n = word;
        valid_n = !busy_c;
        last_n = !busy_c && ch == C_LAST && kk == K_LAST;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ch <= '0;
      k <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      fid <= '0;
      tx_overrun <= 1'b0;
    end else begin
      state <= state_n;
      ch <= ch_n;
      k <= k_n;
      out_data <= data_n;
      out_valid <= valid_n;
      out_last <= last_n;
      fid <= fid_n;
      tx_overrun <= ovr_n;
    end
endmodule
